// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage with a credit-managed prefetch queue.
// Requests are issued only when a queue slot is reserved for their response.
module fetch_prefetch #(
    parameter int unsigned    N        = 64,
    parameter int unsigned    W        = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int unsigned    STEP     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_F,
    input  logic [N-1:0] redirect_pc_F,
    output logic         imem_req_valid,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_rsp_valid,
    input  logic [W-1:0] imem_rsp_data,
    output logic         inst_valid_D,
    output logic [W-1:0] inst_D,
    output logic [N-1:0] pc_D,
    input  logic         inst_ready_D
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [N-1:0]  r_pc;
    logic [N-1:0]  r_rsp_pc;
    logic [W-1:0]  r_inst_q [DEPTH];
    logic [N-1:0]  r_pc_q   [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic [CW:0]   w_in_use;
    logic          w_credit;
    logic          w_fire;
    logic          w_deq;
    logic          w_enq;
    logic [CW-1:0] w_out_after_rsp;

    // Every in-flight request already owns a queue slot, so the sum bounds both.
    assign w_in_use        = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit        = w_in_use < (CW+1)'(DEPTH);
    assign imem_req_valid  = !reset && !redirect_F && w_credit;
    assign imem_req_addr   = r_pc;
    assign w_fire          = imem_req_valid && imem_req_ready;
    assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);

    assign inst_valid_D = !reset && (r_count != '0);
    assign inst_D       = r_inst_q[r_rd_ptr];
    assign pc_D         = r_pc_q[r_rd_ptr];
    assign w_deq        = inst_valid_D && inst_ready_D;
    assign w_enq        = imem_rsp_valid && (r_drop == '0) && !redirect_F && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_F) begin
            // Requests still in flight become stale and are counted off as they return.
            r_pc          <= redirect_pc_F;
            r_rsp_pc      <= redirect_pc_F;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= w_out_after_rsp;
            r_drop        <= w_out_after_rsp;
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + N'(STEP);
            end
            r_outstanding <= w_out_after_rsp + CW'(w_fire);
            if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rsp_pc <= r_rsp_pc + N'(STEP);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_inst_q[r_wr_ptr] <= imem_rsp_data;
            r_pc_q[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: in-order variable-latency memory
// model plus a queue-level reference of what decode should observe.
module tb_fetch_prefetch;

    localparam int unsigned N     = 32;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned STEP  = 4;
    localparam logic [31:0] RPC   = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          redirect_F = 1'b0;
    logic [N-1:0]  redirect_pc_F = '0;
    logic          imem_req_valid;
    logic [N-1:0]  imem_req_addr;
    logic          imem_req_ready = 1'b0;
    logic          imem_rsp_valid = 1'b0;
    logic [W-1:0]  imem_rsp_data = '0;
    logic          inst_valid_D;
    logic [W-1:0]  inst_D;
    logic [N-1:0]  pc_D;
    logic          inst_ready_D = 1'b0;

    req_t        memq[$];
    ent_t        held[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lastDue = 0;
    int          latMin = 1;
    int          latMax = 1;
    logic [31:0] expReqPc = RPC;
    int          checks = 0;
    int          failures = 0;

    fetch_prefetch #(
        .N(N), .W(W), .DEPTH(DEPTH), .RESET_PC(RPC), .STEP(STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_F(redirect_F),
        .redirect_pc_F(redirect_pc_F),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid_D(inst_valid_D),
        .inst_D(inst_D),
        .pc_D(pc_D),
        .inst_ready_D(inst_ready_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory response for the coming cycle: oldest pending request once it is due.
    always @(posedge clk) begin
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Reference model: applies the events of this cycle just before the edge that commits them.
    always @(negedge clk) begin : model
        req_t r;
        ent_t e;
        bit   keep;
        keep = 1'b0;
        if (reset) begin
            memq.delete();
            held.delete();
            epoch    = epoch + 1;
            expReqPc = RPC;
            lastDue  = cyc;
        end else begin
            if (imem_rsp_valid && memq.size() > 0) begin
                r = memq.pop_front();
                if (!redirect_F && r.epoch == epoch) begin
                    e.inst = memf(r.addr);
                    e.pc   = r.addr;
                    keep   = 1'b1;
                end
            end
            if (redirect_F) begin
                held.delete();
                epoch    = epoch + 1;
                expReqPc = redirect_pc_F;
            end else begin
                if (inst_valid_D && inst_ready_D && held.size() > 0) void'(held.pop_front());
                if (keep) held.push_back(e);
                if (imem_req_valid && imem_req_ready) begin
                    r.addr  = imem_req_addr;
                    r.epoch = epoch;
                    r.due   = cyc + int'($urandom_range(latMin, latMax));
                    if (r.due <= lastDue) r.due = lastDue + 1;
                    lastDue = r.due;
                    memq.push_back(r);
                    expReqPc = expReqPc + STEP;
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        redirect_F = 1'b0;
        repeat (2) nextCycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nextCycle();
        #2;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_req_valid got=%0b exp=0", imem_req_valid);
        end
        checks++;
        if (inst_valid_D !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_inst_valid got=%0b exp=0", inst_valid_D);
        end
        nextCycle();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        #2;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            failures++;
            $display("[TB] FAIL reset_first_req got valid=%0b addr=%h exp valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, RPC);
        end
    endtask

    task automatic test_stream();
        latMin = 1; latMax = 1;
        imem_req_ready = 1'b1;
        inst_ready_D = 1'b1;
        doReset();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ea;
            logic [31:0] ep;
            ea = 32'(STEP * i);
            ep = 32'(STEP * (i - 2));
            #2;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== ea) begin
                failures++;
                $display("[TB] FAIL stream_req cyc=%0d got valid=%0b addr=%h exp valid=1 addr=%h",
                         i, imem_req_valid, imem_req_addr, ea);
            end
            checks++;
            if (inst_valid_D !== (i >= 2)) begin
                failures++;
                $display("[TB] FAIL stream_valid cyc=%0d got=%0b exp=%0b", i, inst_valid_D, (i >= 2));
            end
            if (i >= 2) begin
                checks++;
                if (pc_D !== ep || inst_D !== memf(ep)) begin
                    failures++;
                    $display("[TB] FAIL stream_head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                             i, pc_D, inst_D, ep, memf(ep));
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_stall();
        int  fires;
        int  delivered;
        bit  seenFire;
        latMin = 1; latMax = 1;
        imem_req_ready = 1'b1;
        inst_ready_D = 1'b0;
        doReset();
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (imem_req_valid && imem_req_ready) fires++;
            nextCycle();
        end
        #2;
        checks++;
        if (fires !== 4) begin
            failures++; $display("[TB] FAIL stall_fires got=%0d exp=4", fires);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_req_valid got=%0b exp=0", imem_req_valid);
        end
        checks++;
        if (inst_valid_D !== 1'b1 || pc_D !== 32'h0) begin
            failures++;
            $display("[TB] FAIL stall_head got valid=%0b pc=%h exp valid=1 pc=0", inst_valid_D, pc_D);
        end
        inst_ready_D = 1'b1;
        delivered = 0;
        seenFire = 1'b0;
        for (int k = 0; k < 20 && (delivered < 4 || !seenFire); k++) begin
            if (inst_valid_D && inst_ready_D && delivered < 4) begin
                checks++;
                if (pc_D !== 32'(STEP * delivered) || inst_D !== memf(32'(STEP * delivered))) begin
                    failures++;
                    $display("[TB] FAIL stall_drain idx=%0d got pc=%h inst=%h exp pc=%h",
                             delivered, pc_D, inst_D, 32'(STEP * delivered));
                end
                delivered++;
            end
            if (imem_req_valid && imem_req_ready && !seenFire) begin
                checks++;
                if (imem_req_addr !== 32'h10) begin
                    failures++;
                    $display("[TB] FAIL stall_resume got=%h exp=00000010", imem_req_addr);
                end
                seenFire = 1'b1;
            end
            nextCycle();
            #2;
        end
        checks++;
        if (delivered < 4 || !seenFire) begin
            failures++;
            $display("[TB] FAIL stall_timeout got delivered=%0d resumed=%0b exp 4 and 1", delivered, seenFire);
        end
    endtask

    task automatic test_redirect_stale();
        bit found;
        latMin = 3; latMax = 3;
        imem_req_ready = 1'b1;
        inst_ready_D = 1'b1;
        doReset();
        nextCycle();
        nextCycle();
        imem_req_ready = 1'b0;
        redirect_F = 1'b1;
        redirect_pc_F = 32'h100;
        #2;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL stale_redirect_req got=%0b exp=0", imem_req_valid);
        end
        nextCycle();
        redirect_F = 1'b0;
        imem_req_ready = 1'b1;
        #2;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL stale_next_req got valid=%0b addr=%h exp valid=1 addr=00000100",
                     imem_req_valid, imem_req_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (inst_valid_D) begin
                found = 1'b1;
                checks++;
                if (pc_D !== 32'h100 || inst_D !== memf(32'h100)) begin
                    failures++;
                    $display("[TB] FAIL stale_first_delivery got pc=%h inst=%h exp pc=00000100 inst=%h",
                             pc_D, inst_D, memf(32'h100));
                end
            end
            nextCycle();
            #2;
        end
        checks++;
        if (!found) begin
            failures++; $display("[TB] FAIL stale_timeout got=0 exp=1");
        end
    endtask

    task automatic test_redirect_collide();
        bit found;
        latMin = 1; latMax = 1;
        imem_req_ready = 1'b1;
        inst_ready_D = 1'b1;
        doReset();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #2;
            if (imem_rsp_valid && inst_valid_D) found = 1'b1;
            else nextCycle();
        end
        checks++;
        if (!found) begin
            failures++; $display("[TB] FAIL collide_setup got=0 exp=1");
        end
        redirect_F = 1'b1;
        redirect_pc_F = 32'h200;
        #1;
        checks++;
        if (inst_valid_D !== 1'b1 || pc_D !== 32'h0) begin
            failures++;
            $display("[TB] FAIL collide_head got valid=%0b pc=%h exp valid=1 pc=0", inst_valid_D, pc_D);
        end
        nextCycle();
        redirect_F = 1'b0;
        #2;
        checks++;
        if (inst_valid_D !== 1'b0) begin
            failures++; $display("[TB] FAIL collide_empty got=%0b exp=0", inst_valid_D);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            failures++;
            $display("[TB] FAIL collide_req got valid=%0b addr=%h exp valid=1 addr=00000200",
                     imem_req_valid, imem_req_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (inst_valid_D) begin
                found = 1'b1;
                checks++;
                if (pc_D !== 32'h200) begin
                    failures++; $display("[TB] FAIL collide_next got=%h exp=00000200", pc_D);
                end
            end
            nextCycle();
            #2;
        end
        checks++;
        if (!found) begin
            failures++; $display("[TB] FAIL collide_timeout got=0 exp=1");
        end
    endtask

    task automatic test_wrap();
        int fireIdx;
        int delIdx;
        latMin = 1; latMax = 1;
        imem_req_ready = 1'b1;
        inst_ready_D = 1'b1;
        doReset();
        repeat (3) nextCycle();
        redirect_F = 1'b1;
        redirect_pc_F = 32'hFFFF_FFFC;
        nextCycle();
        redirect_F = 1'b0;
        fireIdx = 0;
        delIdx = 0;
        for (int k = 0; k < 15 && (fireIdx < 3 || delIdx < 3); k++) begin
            logic [31:0] ef;
            logic [31:0] ed;
            ef = 32'hFFFF_FFFC + 32'(STEP * fireIdx);
            ed = 32'hFFFF_FFFC + 32'(STEP * delIdx);
            #2;
            if (imem_req_valid && imem_req_ready && fireIdx < 3) begin
                checks++;
                if (imem_req_addr !== ef) begin
                    failures++; $display("[TB] FAIL wrap_req idx=%0d got=%h exp=%h", fireIdx, imem_req_addr, ef);
                end
                fireIdx++;
            end
            if (inst_valid_D && inst_ready_D && delIdx < 3) begin
                checks++;
                if (pc_D !== ed || inst_D !== memf(ed)) begin
                    failures++;
                    $display("[TB] FAIL wrap_pc idx=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                             delIdx, pc_D, inst_D, ed, memf(ed));
                end
                delIdx++;
            end
            nextCycle();
        end
        checks++;
        if (fireIdx < 3 || delIdx < 3) begin
            failures++; $display("[TB] FAIL wrap_timeout got fires=%0d deliveries=%0d exp 3 and 3", fireIdx, delIdx);
        end
    endtask

    task automatic test_reset_midop();
        bit found;
        latMin = 3; latMax = 3;
        imem_req_ready = 1'b1;
        inst_ready_D = 1'b0;
        doReset();
        repeat (5) nextCycle();
        reset = 1'b1;
        #2;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid_D !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got req=%0b inst=%0b exp 0 and 0", imem_req_valid, inst_valid_D);
        end
        nextCycle();
        nextCycle();
        reset = 1'b0;
        inst_ready_D = 1'b1;
        latMin = 1; latMax = 1;
        #2;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            failures++;
            $display("[TB] FAIL midreset_first_req got valid=%0b addr=%h exp valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, RPC);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (inst_valid_D) begin
                found = 1'b1;
                checks++;
                if (pc_D !== RPC || inst_D !== memf(RPC)) begin
                    failures++;
                    $display("[TB] FAIL midreset_first_delivery got pc=%h inst=%h exp pc=%h", pc_D, inst_D, RPC);
                end
            end
            nextCycle();
            #2;
        end
        checks++;
        if (!found) begin
            failures++; $display("[TB] FAIL midreset_timeout got=0 exp=1");
        end
    endtask

    task automatic test_random();
        latMin = 1; latMax = 1;
        doReset();
        for (int i = 0; i < 600; i++) begin
            bit expV;
            if (i % 100 == 0) latMax = int'($urandom_range(1, 5));
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready_D   = ($urandom_range(0, 2) != 0);
            redirect_F     = ($urandom_range(0, 29) == 0);
            redirect_pc_F  = 32'($urandom) & 32'hFFFF_FFFC;
            #2;
            expV = !redirect_F && ((held.size() + memq.size()) < DEPTH);
            checks++;
            if (imem_req_valid !== expV) begin
                failures++; $display("[TB] FAIL rand_req_valid cyc=%0d got=%0b exp=%0b", i, imem_req_valid, expV);
            end
            if (expV) begin
                checks++;
                if (imem_req_addr !== expReqPc) begin
                    failures++; $display("[TB] FAIL rand_req_addr cyc=%0d got=%h exp=%h", i, imem_req_addr, expReqPc);
                end
            end
            checks++;
            if (inst_valid_D !== (held.size() != 0)) begin
                failures++;
                $display("[TB] FAIL rand_inst_valid cyc=%0d got=%0b exp=%0b", i, inst_valid_D, (held.size() != 0));
            end
            if (held.size() != 0) begin
                checks++;
                if (pc_D !== held[0].pc || inst_D !== held[0].inst) begin
                    failures++;
                    $display("[TB] FAIL rand_head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                             i, pc_D, inst_D, held[0].pc, held[0].inst);
                end
            end
            nextCycle();
        end
        redirect_F = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stale();
        test_redirect_collide();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction-fetch stage with a decoupled prefetch queue. Generates sequential PCs, issues in-order requests to a variable-latency instruction memory, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode under a valid/ready handshake. A redirect (taken branch, exception) reloads the PC, flushes the queue and discards all responses still in flight. It sits between the branch-resolution logic and the F/D pipeline register.

## Interface
- N, 64: address/PC width.
- W, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC after reset.
- STEP, 4: PC increment per sequential fetch.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect_F  in  1  load redirect_pc_F into PC, flush queue, kill in-flight requests.
- redirect_pc_F  in  N  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  N  request address (= PC).
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response valid (in order, no backpressure, ≥1 cycle after its request).
- imem_rsp_data  in  W  returned instruction.
- inst_valid_D  out  1  queue head valid.
- inst_D  out  W  head instruction.
- pc_D  out  N  head PC.
- inst_ready_D  in  1  decode consumes head when inst_valid_D is high.

## Operation
- State: pc (N), rsp_pc (N), queue of {inst, pc} with rd/wr pointers and count (0..DEPTH), outstanding (0..DEPTH), drop (0..DEPTH).
- Credit rule: imem_req_valid = !reset && !redirect_F && (count + outstanding < DEPTH). A queue slot is therefore reserved for every request; overflow is impossible by construction.
- imem_req_addr = pc always (also while valid is low).
- Request fire (valid && ready): pc <= pc + STEP; outstanding increments.
- Response (imem_rsp_valid): outstanding decrements. If drop > 0: drop decrements, data discarded, rsp_pc unchanged. Else: {imem_rsp_data, rsp_pc} written at wr pointer, rsp_pc <= rsp_pc + STEP.
- Fire and response in the same cycle: outstanding unchanged.
- Dequeue: inst_valid_D = (count != 0); inst_D/pc_D = head entry (combinational from the queue); valid && ready advances rd pointer.
- Enqueue and dequeue in the same cycle: count unchanged; legal at count = DEPTH, since credit guarantees the write.
- Redirect (highest priority over everything except reset): pc <= redirect_pc_F, rsp_pc <= redirect_pc_F, count/pointers <= 0, drop <= outstanding − imem_rsp_valid, outstanding <= outstanding − imem_rsp_valid. No request is issued that cycle. Any response arriving that cycle is discarded. A head consumed by decode that cycle counts as delivered. Any enqueue that cycle is lost.
- Redirect while drop > 0: drop is recomputed by the same formula. Outstanding already includes the older stale requests, so they are not double counted.
- Arithmetic: pc and rsp_pc wrap modulo 2^N. outstanding, drop and count are clog2(DEPTH)+1 bits wide.
- Reset: pc = rsp_pc = RESET_PC; count = outstanding = drop = 0; pointers = 0. During the reset cycle imem_req_valid = 0 and inst_valid_D = 0. Reset mid-operation abandons in-flight requests. The memory must be reset together with this block; no responses may arrive after reset.

## Timing
- Request for PC p fires at cycle t. Earliest response is t+1. Entry becomes visible (inst_valid_D = 1) at the cycle after the response. Minimum fetch-to-decode latency is 2 cycles.
- With single-cycle memory, always ready, and DEPTH ≥ 2: sustained throughput is 1 instruction/cycle.
- Redirect asserted at cycle t: imem_req_valid = 1 with addr = redirect_pc_F at t+1, provided the credit rule allows (outstanding may still hold stale requests). Earliest valid instruction at the target is at t+3.
- First request after reset release: the cycle after reset deasserts, addr = RESET_PC.
- Outputs are valid every cycle with no combinational path from imem_rsp_* to inst_*_D. imem_req_valid depends combinationally on redirect_F and reset only.

## Test plan
- Reset then 1-cycle memory, always ready, decode always ready: requests at 0x0, 0x4, 0x8, … on consecutive cycles. pc_D sequence is 0x0, 0x4, 0x8, … with inst_D matching memory. inst_valid_D first high 2 cycles after the first fire.
- Decode stalled (inst_ready_D = 0), DEPTH = 4: exactly 4 requests fire, then imem_req_valid stays 0. count = 4 with 4 entries held. Releasing ready drains 0x0..0xC in order and fetch resumes at 0x10.
- 3-cycle memory latency with 2 requests outstanding; redirect to 0x100: the 2 stale responses are discarded (drop 2→0). The next request is addr 0x100. First delivered pc_D is 0x100, and no stale instruction ever appears.
- Redirect in the same cycle as a response and a decode dequeue: the response is dropped, the dequeued head is delivered once, and the queue is empty next cycle.
- N = 32, redirect to 0xFFFF_FFFC: fetches 0xFFFF_FFFC then 0x0000_0000. pc_D wraps identically.
- Assert reset with the queue full and requests outstanding (memory reset too): next cycle inst_valid_D = 0 and imem_req_valid = 0. After release the first request is at RESET_PC.
